mdu_seq: RTL

Iterative unsigned multiply/divide sequencer for the RV32 core. It accepts one MUL/MULHU/DIVU/REMU request at a time and produces one result bit per cycle over 32 iterations. Every add and subtract in those iterations goes through the shared 32-bit ALU: this block drives the ALU operand/op inputs and reads back its result. Local logic handles only shifting, carry/borrow detection and bookkeeping. The execute-stage mux hands the ALU to this block while `o_alu_busy` is high.

---
 rtl/mdu_seq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
`timescale 1ns/1ps
// mdu_seq: iterative unsigned MUL/MULHU/DIVU/REMU sequencer for the RV32 core.
//   Produces one result bit per cycle over 32 RUN cycles. Every add/subtract is
//   performed by the shared execute-stage ALU, which this block owns while
//   o_alu_busy is high. Locally the block only shifts, detects carry/borrow and
//   counts iterations.
// Latency: the response is valid 33 cycles after the accept cycle (32 RUN
//   cycles). A divide by zero skips RUN, and its response is valid in the cycle
//   after accept.
// Backpressure: one request in flight. o_req_ready is high only in IDLE. The
//   response is held in DONE until i_rsp_ready. IDLE is re-entered the cycle
//   after the response handshake.
//
// Ports:
//   i_clk, i_rst_n               clock (rising edge), async active-low reset
//   i_req_valid / o_req_ready    request handshake
//   i_req_op                     00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   i_req_a, i_req_b             multiplicand/dividend, multiplier/divisor
//   o_rsp_valid / i_rsp_ready    response handshake
//   o_rsp_data                   registered result
//   o_alu_busy                   high while RUN drives the shared ALU
//   o_alu_a, o_alu_b, o_alu_op   ALU operands and op (ADD=0000, SUB=0001)
//   i_alu_data                   combinational ALU result, same cycle
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [1:0]      i_req_op,
  input  logic [XLEN-1:0] i_req_a,
  input  logic [XLEN-1:0] i_req_b,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_alu_busy,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_op,
  input  logic [XLEN-1:0] i_alu_data
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  localparam logic [4:0] CNT_LAST_LOAD = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state;
  logic [1:0]      op;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mq;
  logic [XLEN-1:0] opnd;
  logic [4:0]      cnt;
  logic [XLEN-1:0] rsp;
  logic            req_ready;
  logic            rsp_valid;
  logic            alu_busy;

  // op[1] selects divide; op[0] selects the high half / remainder.
  logic            is_div;
  logic [XLEN-1:0] sh;
  logic            carry;
  logic            ge;
  logic [XLEN-1:0] acc_nxt;
  logic [XLEN-1:0] mq_nxt;
  logic            req_fire;
  logic            req_div_zero;

  assign is_div       = op[1];
  assign req_fire     = i_req_valid & req_ready;
  assign req_div_zero = i_req_op[1] & (i_req_b == '0);

  // Dividend bit shifted into the partial remainder for a divide step.
  assign sh = {acc[XLEN-2:0], mq[XLEN-1]};

  // ALU drive depends only on state and registers, never on the request port.
  always_comb begin
    o_alu_a  = '0;
    o_alu_b  = '0;
    o_alu_op = ALU_ADD;
    if (state == RUN) begin
      o_alu_b = opnd;
      if (is_div) begin
        o_alu_a  = sh;
        o_alu_op = ALU_SUB;
      end else begin
        o_alu_a  = acc;
        o_alu_op = ALU_ADD;
      end
    end
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    // An unsigned add wrapped iff the sum is below either operand.
    carry   = (i_alu_data < acc);
    // acc[31] set means the shifted remainder is really 33 bits wide, so it is
    // at least the divisor regardless of the 32-bit compare.
    ge      = acc[XLEN-1] | (sh >= opnd);
    acc_nxt = acc;
    mq_nxt  = mq;
    if (is_div) begin
      if (ge) begin
        acc_nxt = i_alu_data;
        mq_nxt  = {mq[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = sh;
        mq_nxt  = {mq[XLEN-2:0], 1'b0};
      end
    end else begin
      if (mq[0]) begin
        acc_nxt = {carry, i_alu_data[XLEN-1:1]};
        mq_nxt  = {i_alu_data[0], mq[XLEN-1:1]};
      end else begin
        acc_nxt = {1'b0, acc[XLEN-1:1]};
        mq_nxt  = {acc[0], mq[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      op        <= OP_MUL;
      acc       <= '0;
      mq        <= '0;
      opnd      <= '0;
      cnt       <= '0;
      rsp       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      alu_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            op        <= i_req_op;
            req_ready <= 1'b0;
            if (req_div_zero) begin
              // RISC-V divide-by-zero results, no iterations needed.
              rsp       <= (i_req_op == OP_DIVU) ? '1 : i_req_a;
              rsp_valid <= 1'b1;
              state     <= DONE;
            end else begin
              acc      <= '0;
              mq       <= i_req_op[1] ? i_req_a : i_req_b;
              opnd     <= i_req_op[1] ? i_req_b : i_req_a;
              cnt      <= CNT_LAST_LOAD;
              alu_busy <= 1'b1;
              state    <= RUN;
            end
          end
        end

        RUN: begin
          acc <= acc_nxt;
          mq  <= mq_nxt;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            // MUL and DIVU return the low/quotient register, the others acc.
            case (op)
              OP_MUL, OP_DIVU:   rsp <= mq_nxt;
              OP_MULHU, OP_REMU: rsp <= acc_nxt;
              default:           rsp <= mq_nxt;
            endcase
            alu_busy  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (i_rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          rsp_valid <= 1'b0;
          alu_busy  <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = req_ready;
  assign o_rsp_valid = rsp_valid;
  assign o_rsp_data  = rsp;
  assign o_alu_busy  = alu_busy;

endmodule
